// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_modexp_ct modular-exponentiation engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_DONE
    } state_t;

    localparam logic MODE_SQM    = 1'b0;
    localparam logic MODE_LADDER = 1'b1;

    // One issue cycle, one cycle per multiplier bit, one writeback cycle.
    function automatic int unsigned mul_cycles(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, MSB-first over a,
// one multiplier bit per cycle; done pulses for one cycle when p is valid.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int ITERS = int'(mul_cycles(WIDTH)) - 2;
    localparam int ITER_W = $clog2(ITERS + 1);

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  n_r;
    logic [WIDTH+1:0]  acc;
    logic [ITER_W-1:0] iter_cnt;
    logic              run;

    // acc < n on entry, so 2*acc + b < 3n and two conditional subtractions suffice.
    function automatic logic [WIDTH+1:0] reduce_step(input logic [WIDTH+1:0] acc_in,
                                                     input logic             bit_in,
                                                     input logic [WIDTH-1:0] bb,
                                                     input logic [WIDTH-1:0] nn);
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] nx;
        nx = {2'b00, nn};
        t  = (acc_in << 1) + (bit_in ? {2'b00, bb} : '0);
        if (t >= nx) t = t - nx;
        if (t >= nx) t = t - nx;
        return t;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            done     <= 1'b0;
            iter_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run      <= 1'b1;
                iter_cnt <= ITER_W'(ITERS);
            end else if (run) begin
                iter_cnt <= iter_cnt - ITER_W'(1);
                if (iter_cnt == ITER_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            a_sh <= a;
            b_r  <= b;
            n_r  <= n;
            acc  <= '0;
        end else if (run) begin
            acc  <= reduce_step(acc, a_sh[WIDTH-1], b_r, n_r);
            a_sh <= a_sh << 1;
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_ct.sv
// Modular exponentiation m = c^d mod n with selectable square-and-multiply or
// constant-time Montgomery ladder, plus a start-to-finish latency counter.
module rsa_modexp_ct
    import rsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] m_out,
    output logic             finish,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] lat_cnt
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state;
    logic             mode_r;
    logic             phase;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] cnt;

    logic             mm_start;
    logic             mm_done;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;

    logic             cur_bit;
    logic             wr_r0;
    logic             next_phase1;
    logic             last_mul;
    logic [WIDTH-1:0] m_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // phase 0 is the squaring (SQM) or the cross product (ladder) of the current bit;
    // in the ladder both products read pre-step values because each writes the register
    // the other one does not read.
    always_comb begin
        cur_bit     = d_r[bit_idx];
        mm_a        = r0;
        mm_b        = r0;
        wr_r0       = 1'b1;
        next_phase1 = 1'b0;
        if (mode_r == MODE_SQM) begin
            if (phase) mm_b = c_r;
            next_phase1 = !phase && cur_bit;
        end else begin
            next_phase1 = !phase;
            if (!phase) begin
                mm_b  = r1;
                wr_r0 = cur_bit;
            end else if (cur_bit) begin
                mm_a  = r1;
                mm_b  = r1;
                wr_r0 = 1'b0;
            end
        end
        last_mul = !next_phase1 && (bit_idx == '0);
        m_next   = wr_r0 ? mm_p : r0;
    end

    assign mm_start = (state == ST_MUL_ISSUE);

    rsa_modmul #(
        .WIDTH(WIDTH)
    ) u_modmul (
        .clk  (clk),
        .rst_n(rst_n),
        .start(mm_start),
        .a    (mm_a),
        .b    (mm_b),
        .n    (n_r),
        .done (mm_done),
        .p    (mm_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            bit_idx <= '0;
            cnt     <= '0;
            m_out   <= '0;
            finish  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            lat_cnt <= '0;
        end else begin
            finish <= 1'b0;
            if (state inside {ST_LOAD, ST_MUL_ISSUE, ST_MUL_WAIT}) cnt <= sat_inc(cnt);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= CNT_W'(1);
                        if (n < WIDTH'(2) || c >= n) begin
                            state   <= ST_DONE;
                            m_out   <= '0;
                            err     <= 1'b1;
                            finish  <= 1'b1;
                            lat_cnt <= CNT_W'(1);
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    bit_idx <= IDX_W'(WIDTH - 1);
                    phase   <= 1'b0;
                    state   <= ST_MUL_ISSUE;
                end
                ST_MUL_ISSUE: state <= ST_MUL_WAIT;
                ST_MUL_WAIT: begin
                    if (mm_done) begin
                        if (last_mul) begin
                            state   <= ST_DONE;
                            m_out   <= m_next;
                            err     <= 1'b0;
                            finish  <= 1'b1;
                            lat_cnt <= sat_inc(cnt);
                        end else begin
                            state <= ST_MUL_ISSUE;
                            if (next_phase1) begin
                                phase <= 1'b1;
                            end else begin
                                phase   <= 1'b0;
                                bit_idx <= bit_idx - IDX_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand and working registers carry no reset; the FSM always loads them before use.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            mode_r <= mode;
            c_r    <= c;
            d_r    <= d;
            n_r    <= n;
        end
        if (state == ST_LOAD) begin
            r0 <= WIDTH'(1);
            r1 <= c_r;
        end else if (state == ST_MUL_WAIT && mm_done) begin
            if (wr_r0) r0 <= mm_p;
            else       r1 <= mm_p;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ct.sv
// Scoreboard bench for rsa_modexp_ct: expected results are queued at start and
// checked against m_out/err/lat_cnt and the observed start-to-finish latency.
module tb_rsa_modexp_ct;

    localparam int W  = 16;
    localparam int CW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode  = 1'b0;
    logic [W-1:0]  c     = '0;
    logic [W-1:0]  d     = '0;
    logic [W-1:0]  n     = '0;
    logic [W-1:0]  m_out;
    logic          finish;
    logic          busy;
    logic          err;
    logic [CW-1:0] lat_cnt;

    typedef struct {
        logic [W-1:0] m;
        logic         e;
        int unsigned  lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rsa_modexp_ct #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .c      (c),
        .d      (d),
        .n      (n),
        .m_out  (m_out),
        .finish (finish),
        .busy   (busy),
        .err    (err),
        .lat_cnt(lat_cnt)
    );

    // Right-to-left binary exponentiation as an independent reference.
    function automatic exp_t model(input logic md, input logic [W-1:0] cc,
                                   input logic [W-1:0] dd, input logic [W-1:0] nn);
        exp_t r;
        longint unsigned acc, base, md_n;
        if (nn < 2 || cc >= nn) begin
            r.m = '0; r.e = 1'b1; r.lat = 1;
            return r;
        end
        acc = 1; base = longint'(cc); md_n = longint'(nn);
        for (int i = 0; i < W; i++) begin
            if (dd[i]) acc = (acc * base) % md_n;
            base = (base * base) % md_n;
        end
        r.m   = W'(acc);
        r.e   = 1'b0;
        r.lat = 2 + (md ? 2 * W : W + $countones(dd)) * (W + 2);
        return r;
    endfunction

    // Start high for one cycle; returns at the negedge one cycle after the accept edge.
    task automatic issue(input logic md, input logic [W-1:0] cc, input logic [W-1:0] dd,
                         input logic [W-1:0] nn, input exp_t ex);
        @(negedge clk);
        mode = md; c = cc; d = dd; n = nn; start = 1'b1;
        sb_q.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        mode = ~md; c = W'($urandom); d = W'($urandom); n = W'($urandom);
    endtask

    task automatic wait_finish(output int t, output bit ok);
        t = 1; ok = 1'b0;
        while (t <= 2000) begin
            if (finish) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (m_out !== '0)   begin n_bad++; $display("FAIL reset_m_out: got %0d want 0", m_out); end
        n_vec++; if (finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", finish); end
        n_vec++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (lat_cnt !== '0)  begin n_bad++; $display("FAIL reset_lat: got %0d want 0", lat_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan_vectors();
        logic         md   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] cv   [6] = '{16'd1394, 16'd1394, 16'd89, 16'd5, 16'd5, 16'd3127};
        logic [W-1:0] dv   [6] = '{16'd2011, 16'd2011, 16'd3, 16'd0, 16'd0, 16'd9};
        logic [W-1:0] nv   [6] = '{16'd3127, 16'd3127, 16'd3127, 16'd7, 16'd7, 16'd3127};
        logic [W-1:0] mv   [6] = '{16'd89, 16'd89, 16'd1394, 16'd1, 16'd1, 16'd0};
        logic         ev   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int unsigned  lv   [6] = '{452, 578, 578, 290, 578, 1};
        int   t;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.m = mv[i]; e.e = ev[i]; e.lat = lv[i];
            issue(md[i], cv[i], dv[i], nv[i], e);
            wait_finish(t, ok);
            e = sb_q.pop_front();
            n_vec++;
            if (!ok || m_out !== e.m || err !== e.e || lat_cnt !== CW'(e.lat)) begin
                n_bad++;
                $display("FAIL plan_%0d: finish=%b m_out=%0d err=%b lat_cnt=%0d want m=%0d err=%b lat=%0d",
                         i, ok, m_out, err, lat_cnt, e.m, e.e, e.lat);
            end
            n_vec++;
            if (t != int'(e.lat)) begin
                n_bad++;
                $display("FAIL plan_%0d_timing: finish after %0d cycles want %0d", i, t, e.lat);
            end
        end
    endtask

    task automatic test_errors();
        int   t;
        bit   ok;
        exp_t e;
        e.m = '0; e.e = 1'b1; e.lat = 1;
        issue(1'b1, 16'd0, 16'd5, 16'd1, e);
        wait_finish(t, ok);
        e = sb_q.pop_front();
        n_vec++;
        if (!ok || t != 1 || m_out !== e.m || err !== e.e || lat_cnt !== CW'(e.lat)) begin
            n_bad++;
            $display("FAIL err_n1: t=%0d m_out=%0d err=%b lat_cnt=%0d want t=1 m=0 err=1 lat=1",
                     t, m_out, err, lat_cnt);
        end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_start_ignored();
        int   t;
        int   extra;
        bit   ok;
        exp_t e;
        e.m = 16'd89; e.e = 1'b0; e.lat = 578;
        issue(1'b1, 16'd1394, 16'd2011, 16'd3127, e);
        repeat (50) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_midrun: got %b want 1", busy); end
        start = 1'b1; mode = 1'b0; c = 16'd5; d = 16'd7; n = 16'd11;
        @(negedge clk);
        start = 1'b0;
        wait_finish(t, ok);
        e = sb_q.pop_front();
        n_vec++;
        if (!ok || m_out !== e.m || err !== e.e || lat_cnt !== CW'(e.lat) || t + 51 != int'(e.lat)) begin
            n_bad++;
            $display("FAIL start_ignored: t=%0d m_out=%0d err=%b lat_cnt=%0d want t=%0d m=%0d lat=%0d",
                     t + 51, m_out, err, lat_cnt, e.lat, e.m, e.lat);
        end
        extra = 0;
        repeat (700) begin
            @(negedge clk);
            if (finish) extra++;
        end
        n_vec++; if (extra != 0) begin n_bad++; $display("FAIL start_ignored_extra: got %0d finishes want 0", extra); end
        n_vec++; if (m_out !== 16'd89) begin n_bad++; $display("FAIL m_out_hold: got %0d want 89", m_out); end
    endtask

    task automatic test_midrun_reset();
        int   t;
        int   seen;
        bit   ok;
        exp_t e;
        e = model(1'b0, 16'd1394, 16'd2011, 16'd3127);
        issue(1'b0, 16'd1394, 16'd2011, 16'd3127, e);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        e = sb_q.pop_back();
        #1;
        n_vec++;
        if (m_out !== '0 || finish !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || lat_cnt !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: m_out=%0d finish=%b busy=%b err=%b lat_cnt=%0d want all 0",
                     m_out, finish, busy, err, lat_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (finish) seen++;
        end
        n_vec++; if (seen != 0) begin n_bad++; $display("FAIL midrun_no_finish: got %0d finishes want 0", seen); end
        e.m = 16'd1394; e.e = 1'b0; e.lat = 578;
        issue(1'b1, 16'd89, 16'd3, 16'd3127, e);
        wait_finish(t, ok);
        e = sb_q.pop_front();
        n_vec++;
        if (!ok || t != int'(e.lat) || m_out !== e.m || err !== e.e || lat_cnt !== CW'(e.lat)) begin
            n_bad++;
            $display("FAIL after_reset_run: t=%0d m_out=%0d err=%b lat_cnt=%0d want t=%0d m=%0d lat=%0d",
                     t, m_out, err, lat_cnt, e.lat, e.m, e.lat);
        end
    endtask

    // Each next start is raised in the finish (DONE) cycle and held into IDLE,
    // so only the IDLE-cycle edge may accept it.
    task automatic test_back_to_back();
        localparam int N = 6;
        int           t;
        bit           ok;
        exp_t         e;
        logic         md;
        logic [W-1:0] cc, dd, nn;
        nn = W'($urandom_range(2, 65535)); cc = W'($urandom_range(0, int'(nn) - 1));
        dd = W'($urandom); md = 1'($urandom_range(0, 1));
        issue(md, cc, dd, nn, model(md, cc, dd, nn));
        for (int i = 0; i < N; i++) begin
            wait_finish(t, ok);
            e = sb_q.pop_front();
            n_vec++;
            if (!ok || t != int'(e.lat) || m_out !== e.m || err !== e.e || lat_cnt !== CW'(e.lat)) begin
                n_bad++;
                $display("FAIL b2b_%0d: t=%0d m_out=%0d err=%b lat_cnt=%0d want t=%0d m=%0d err=%b lat=%0d",
                         i, t, m_out, err, lat_cnt, e.lat, e.m, e.e, e.lat);
            end
            if (i < N - 1) begin
                nn = W'($urandom_range(2, 65535));
                cc = (i == 2) ? nn : W'($urandom_range(0, int'(nn) - 1));
                dd = W'($urandom); md = 1'($urandom_range(0, 1));
                mode = md; c = cc; d = dd; n = nn; start = 1'b1;
                sb_q.push_back(model(md, cc, dd, nn));
                @(negedge clk);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_errors();
        test_start_ignored();
        test_midrun_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
